// File: rtl/arm_imm_encoder_if.sv
//------------------------------------------------------------------------------
// Module   : arm_imm_encoder_if
// Brief    : Request/result handshake bundle for the rotated-immediate encoder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface arm_imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] value;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic        encodable;
  logic [11:0] imm12;
  logic        carry;

  modport master (
    output in_valid, value, cin, out_ready,
    input  in_ready, out_valid, encodable, imm12, carry
  );

  modport slave (
    input  in_valid, value, cin, out_ready,
    output in_ready, out_valid, encodable, imm12, carry
  );
endinterface

`default_nettype wire

// File: rtl/arm_imm_encoder.sv
//------------------------------------------------------------------------------
// Module   : arm_imm_encoder
// Brief    : Encodes a 32-bit constant into the ARM {rot, imm8} operand-2 field,
//            lowest rotation first. Define ARM_IMM_ENC_PARALLEL_EN to test all
//            sixteen rotations in a single cycle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module arm_imm_encoder (
  input  wire                 clk,
  input  wire                 rst_n,
  arm_imm_encoder_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_value;
  logic        r_cin;
  logic        r_encodable;
  logic [11:0] r_imm12;
  logic        r_carry;

  logic        w_hit;
  logic [3:0]  w_hit_rot;
  logic [7:0]  w_hit_imm8;
  logic        w_last;
  logic        w_hit_carry;

  // Left-rotate by 2*r: the inverse of the decode-side ROR.
  function automatic logic [31:0] rol2(input logic [31:0] v, input logic [3:0] r);
    logic [63:0] d;
    d = {v, v} << {r, 1'b0};
    return d[63:32];
  endfunction

`ifdef ARM_IMM_ENC_PARALLEL_EN
  logic [31:0] w_tk;

  // Scan high to low so the lowest matching rotation is the one left standing.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_rot  = 4'd0;
    w_hit_imm8 = 8'd0;
    w_tk       = 32'd0;
    for (int k = 15; k >= 0; k--) begin
      w_tk = rol2(r_value, k[3:0]);
      if (w_tk[31:8] == 24'd0) begin
        w_hit      = 1'b1;
        w_hit_rot  = k[3:0];
        w_hit_imm8 = w_tk[7:0];
      end
    end
  end

  assign w_last = 1'b1;
`else
  logic [3:0]  r_rot;
  logic [31:0] w_t;

  assign w_t        = rol2(r_value, r_rot);
  assign w_hit      = (w_t[31:8] == 24'd0);
  assign w_hit_rot  = r_rot;
  assign w_hit_imm8 = w_t[7:0];
  assign w_last     = (r_rot == 4'd15);
`endif

  assign w_hit_carry = (w_hit_rot == 4'd0) ? r_cin : r_value[31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_value     <= 32'd0;
      r_cin       <= 1'b0;
      r_encodable <= 1'b0;
      r_imm12     <= 12'd0;
      r_carry     <= 1'b0;
`ifndef ARM_IMM_ENC_PARALLEL_EN
      r_rot       <= 4'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_value     <= bus.value;
            r_cin       <= bus.cin;
            r_encodable <= 1'b0;
            r_imm12     <= 12'd0;
            r_carry     <= 1'b0;
`ifndef ARM_IMM_ENC_PARALLEL_EN
            r_rot       <= 4'd0;
`endif
            r_state     <= S_SEARCH;
          end
        end

        S_SEARCH: begin
          if (w_hit) begin
            r_encodable <= 1'b1;
            r_imm12     <= {w_hit_rot, w_hit_imm8};
            r_carry     <= w_hit_carry;
            r_state     <= S_DONE;
          end else if (w_last) begin
            r_encodable <= 1'b0;
            r_imm12     <= 12'd0;
            r_carry     <= 1'b0;
            r_state     <= S_DONE;
          end else begin
`ifndef ARM_IMM_ENC_PARALLEL_EN
            r_rot       <= r_rot + 4'd1;
`endif
          end
        end

        S_DONE: begin
          if (bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.encodable = r_encodable;
  assign bus.imm12     = r_imm12;
  assign bus.carry     = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_arm_imm_encoder.sv
//------------------------------------------------------------------------------
// Module   : tb_arm_imm_encoder
// Brief    : Self-checking bench for arm_imm_encoder against a decode-based model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_arm_imm_encoder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  arm_imm_encoder_if bus ();

  arm_imm_encoder u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] v, input int s);
    logic [63:0] d;
    d = {v, v} >> s;
    return d[31:0];
  endfunction

  // Reference: find the smallest rot whose decode reproduces the value.
  function automatic void model(input logic [31:0] v, input logic c,
                                output logic enc, output logic [11:0] imm,
                                output logic cy, output int lat);
    logic [31:0] cand;
    logic [7:0]  i8;
    enc = 1'b0; imm = 12'd0; cy = 1'b0; lat = 16;
    for (int rot = 15; rot >= 0; rot--) begin
      cand = ror32(v, 32 - 2 * rot);
      i8   = cand[7:0];
      if (ror32({24'd0, i8}, 2 * rot) == v) begin
        enc = 1'b1;
        imm = {rot[3:0], i8};
        cy  = (rot == 0) ? c : v[31];
        lat = rot + 1;
      end
    end
`ifdef ARM_IMM_ENC_PARALLEL_EN
    lat = 1;
`endif
  endfunction

  task automatic request(input logic [31:0] v, input logic c, input int hold);
    logic        e_enc, e_cy;
    logic [11:0] e_imm;
    int          e_lat, lat, wait_cnt;
    model(v, c, e_enc, e_imm, e_cy, e_lat);
    wait_cnt = 0;
    while (!bus.in_ready && wait_cnt < 40) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("in_ready_before_req", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.value    = v;
    bus.cin      = c;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.value    = $urandom;
    bus.cin      = 1'($urandom_range(0, 1));
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      bus.value = $urandom;
    end
    check($sformatf("latency_%h", v), lat, e_lat);
    check($sformatf("encodable_%h", v), {31'd0, bus.encodable}, {31'd0, e_enc});
    check($sformatf("imm12_%h", v), {20'd0, bus.imm12}, {20'd0, e_imm});
    check($sformatf("carry_%h", v), {31'd0, bus.carry}, {31'd0, e_cy});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      bus.value = $urandom;
      bus.cin   = ~bus.cin;
      check("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("hold_imm12", {20'd0, bus.imm12}, {20'd0, e_imm});
      check("hold_carry", {31'd0, bus.carry}, {31'd0, e_cy});
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("in_ready_after_take", {31'd0, bus.in_ready}, 32'd1);
    check("out_valid_after_take", {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    logic [7:0]  ri;
    logic [3:0]  rr;
    n_checks      = 0;
    n_fails       = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.value     = 32'd0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_encodable", {31'd0, bus.encodable}, 32'd0);
    check("rst_imm12", {20'd0, bus.imm12}, 32'd0);
    check("rst_carry", {31'd0, bus.carry}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors from the boundary cases.
    request(32'h0000_00FF, 1'b1, 0);
    request(32'hFF00_0000, 1'b0, 0);
    request(32'h0000_03FC, 1'b1, 0);
    request(32'hF000_000F, 1'b0, 0);
    request(32'h0000_0101, 1'b1, 0);
    request(32'h0000_0000, 1'b0, 0);
    request(32'h0000_0000, 1'b1, 0);
    request(32'hFF00_0000, 1'b0, 5);

    // Asynchronous reset in the middle of a long search.
    bus.in_valid = 1'b1;
    bus.value    = 32'h0000_03FC;
    bus.cin      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (16) begin
      @(negedge clk);
      check("postrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    end
    request(32'h0000_00FF, 1'b0, 0);

    // Random mix of raw values and guaranteed-encodable constants.
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 0) begin
        request($urandom, 1'($urandom_range(0, 1)), 0);
      end else begin
        ri = 8'($urandom_range(0, 255));
        rr = 4'($urandom_range(0, 15));
        request(ror32({24'd0, ri}, 2 * int'(rr)), 1'($urandom_range(0, 1)), i % 3);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
